// File: rtl/mips_pkg.sv
// Shared types and instruction-field constants for the fetch stage and its controller.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } fetch_state_t;

  localparam int OP_MSB          = 31;
  localparam int OP_LSB          = 26;
  localparam int FUNCT_MSB       = 5;
  localparam int FUNCT_LSB       = 0;
  localparam int BYTES_PER_INSTR = 4;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Byte-wide req/ack memory read bus between the fetch unit (master) and memory (slave).
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );

endinterface

// File: rtl/ir_byte_assembler.sv
// Shadow register filled one byte at a time; commit copies it into instr atomically.
module ir_byte_assembler
  import mips_pkg::*;
(
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               wr_en,
  input  logic [$clog2(BYTES_PER_INSTR)-1:0] byte_idx,
  input  logic [7:0]                         wr_data,
  input  logic                               commit,
  input  logic                               discard,
  output logic [8*BYTES_PER_INSTR-1:0]       instr
);

  logic [8*BYTES_PER_INSTR-1:0] shadow;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow <= '0;
      instr  <= '0;
    end else begin
      if (discard)
        shadow <= '0;
      else if (wr_en)
        shadow[8*byte_idx +: 8] <= wr_data;
      // The last byte bypasses the shadow so instr updates on the same edge it arrives.
      if (commit)
        instr <= {wr_data, shadow[8*(BYTES_PER_INSTR-1)-1:0]};
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Byte-serial instruction fetch: four req/ack reads from pc assembled into one 32-bit word.
// Optional wait-state timeout enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_start,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  pc,
  instr_fetch_unit_if.master mem,
  output logic [31:0]        instr,
  output logic [5:0]         op,
  output logic [5:0]         funct,
  output logic               instr_valid,
  output logic               busy,
  output logic               fetch_err
);

  localparam int IDX_W = $clog2(BYTES_PER_INSTR);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_INSTR - 1);

  fetch_state_t      state;
  logic [ADDR_W-1:0] base;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_next;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] rdata;
  logic              wr_en;
  logic              commit;
  logic              discard;

  assign mem.mem_req  = req_q;
  assign mem.mem_addr = addr_q;
  assign rdata        = mem.mem_rdata;
  assign idx_next     = idx + 1'b1;

  always_comb begin
    wr_en   = 1'b0;
    commit  = 1'b0;
    discard = 1'b0;
    if (state == REQ) begin
      discard = flush;
      wr_en   = mem.mem_ack && !flush;
      commit  = wr_en && (idx == LAST_IDX);
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WAIT_W-1:0] wait_cnt;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      base        <= '0;
      idx         <= '0;
      req_q       <= 1'b0;
      addr_q      <= '0;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt    <= '0;
      fetch_err   <= 1'b0;
`endif
    end else begin
`ifdef FETCH_TIMEOUT_EN
      fetch_err <= 1'b0;
`endif
      case (state)
        IDLE, DONE: begin
          if (flush) begin
            instr_valid <= 1'b0;
          end else if (fetch_start) begin
            base        <= pc;
            idx         <= '0;
            addr_q      <= pc;
            req_q       <= 1'b1;
            busy        <= 1'b1;
            instr_valid <= 1'b0;
            state       <= REQ;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
          end
        end
        REQ: begin
          if (flush) begin
            state       <= IDLE;
            idx         <= '0;
            req_q       <= 1'b0;
            busy        <= 1'b0;
            instr_valid <= 1'b0;
          end else if (mem.mem_ack) begin
`ifdef FETCH_TIMEOUT_EN
            wait_cnt <= '0;
`endif
            if (idx == LAST_IDX) begin
              state       <= DONE;
              idx         <= '0;
              req_q       <= 1'b0;
              busy        <= 1'b0;
              instr_valid <= 1'b1;
            end else begin
              idx    <= idx_next;
              addr_q <= base + ADDR_W'(idx_next);
            end
          end
`ifdef FETCH_TIMEOUT_EN
          else if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES)) begin
            state       <= IDLE;
            idx         <= '0;
            req_q       <= 1'b0;
            busy        <= 1'b0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b1;
            wait_cnt    <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef FETCH_TIMEOUT_EN
  assign fetch_err = 1'b0;
`endif

  ir_byte_assembler u_asm (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .byte_idx (idx),
    .wr_data  (rdata[7:0]),
    .commit   (commit),
    .discard  (discard),
    .instr    (instr)
  );

  assign op    = instr[OP_MSB:OP_LSB];
  assign funct = instr[FUNCT_MSB:FUNCT_LSB];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: vector table, corner-case sequences, randomized fetches.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_start;
  logic        flush;
  logic [7:0]  pc;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        instr_valid;
  logic        busy;
  logic        fetch_err;

  instr_fetch_unit_if #(.ADDR_W(8), .DATA_W(8)) mem_bus ();

  instr_fetch_unit #(.ADDR_W(8), .DATA_W(8), .TIMEOUT_CYCLES(15)) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_start (fetch_start),
    .flush       (flush),
    .pc          (pc),
    .mem         (mem_bus.master),
    .instr       (instr),
    .op          (op),
    .funct       (funct),
    .instr_valid (instr_valid),
    .busy        (busy),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  int unsigned total  = 0;
  int unsigned passed = 0;
  logic [31:0] model_instr;

  typedef struct {
    logic [7:0]  pc;
    logic [31:0] word;
    logic [5:0]  exp_op;
    logic [5:0]  exp_funct;
    int          gap;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_settled(input string tag, input logic exp_valid);
    check({tag, "_req"},   {31'd0, mem_bus.mem_req}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy}, 32'd0);
    check({tag, "_valid"}, {31'd0, instr_valid}, {31'd0, exp_valid});
    check({tag, "_instr"}, instr, model_instr);
    check({tag, "_op"},    {26'd0, op}, {26'd0, model_instr[31:26]});
    check({tag, "_funct"}, {26'd0, funct}, {26'd0, model_instr[5:0]});
  endtask

  // One fetch at address a; byte k arrives after 'gap' idle wait cycles.
  // flush_at=k flushes before byte k is delivered; poke drives fetch_start during waits.
  task automatic run_fetch(input logic [7:0] a, input logic [31:0] word, input int gap,
                           input int flush_at, input bit poke);
    logic [7:0] exp_addr;
    fetch_start = 1'b1;
    pc          = a;
    flush       = 1'b0;
    tick();
    fetch_start = 1'b0;
    pc          = ~a;
    check("accept_busy",  {31'd0, busy}, 32'd1);
    check("accept_valid", {31'd0, instr_valid}, 32'd0);
    check("accept_instr", instr, model_instr);
    for (int k = 0; k < 4; k++) begin
      exp_addr = a + 8'(k);
      if (k == flush_at) begin
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_settled("flush_req", 1'b0);
        return;
      end
      for (int w = 0; w < gap; w++) begin
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = 8'($urandom);
        if (poke) begin
          fetch_start = 1'b1;
          pc          = 8'($urandom);
        end
        check("wait_addr", {24'd0, mem_bus.mem_addr}, {24'd0, exp_addr});
        check("wait_req",  {31'd0, mem_bus.mem_req}, 32'd1);
        check("wait_busy", {31'd0, busy}, 32'd1);
        tick();
        fetch_start = 1'b0;
      end
      check("beat_addr",  {24'd0, mem_bus.mem_addr}, {24'd0, exp_addr});
      check("beat_req",   {31'd0, mem_bus.mem_req}, 32'd1);
      check("beat_valid", {31'd0, instr_valid}, 32'd0);
      mem_bus.mem_ack   = 1'b1;
      mem_bus.mem_rdata = word[8*k +: 8];
      tick();
      mem_bus.mem_ack   = 1'b0;
      if (k < 3) check("beat_busy", {31'd0, busy}, 32'd1);
    end
    model_instr = word;
    check_settled("done", 1'b1);
  endtask

  initial begin
    vecs[0] = '{8'h10, 32'h8C000020, 6'b100011, 6'b100000, 0};
    vecs[1] = '{8'h10, 32'h8C000020, 6'b100011, 6'b100000, 2};
    vecs[2] = '{8'hFE, 32'h12345678, 6'b000100, 6'b111000, 0};
    vecs[3] = '{8'h7F, 32'hAABBCCDD, 6'b101010, 6'b011101, 1};
    vecs[4] = '{8'h00, 32'hFC00003F, 6'b111111, 6'b111111, 3};

    reset             = 1'b0;
    fetch_start       = 1'b0;
    flush             = 1'b0;
    pc                = '0;
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = '0;
    model_instr       = '0;

    #12;
    check_settled("reset", 1'b0);
    check("reset_addr", {24'd0, mem_bus.mem_addr}, 32'd0);
    check("reset_err",  {31'd0, fetch_err}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();

    foreach (vecs[i]) begin
      run_fetch(vecs[i].pc, vecs[i].word, vecs[i].gap, -1, 1'b0);
      check("vec_op",    {26'd0, op},    {26'd0, vecs[i].exp_op});
      check("vec_funct", {26'd0, funct}, {26'd0, vecs[i].exp_funct});
    end

    // fetch_start during REQ must not disturb the in-flight fetch
    run_fetch(8'h40, 32'h01234567, 2, -1, 1'b1);

    // flush after two bytes keeps the previous instruction
    run_fetch(8'h20, 32'hDEADBEEF, 1, 2, 1'b0);

    // flush in DONE clears valid only
    run_fetch(8'h30, 32'hCAFEF00D, 0, -1, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_settled("flush_done", 1'b0);

    // flush and fetch_start together: no fetch; ack while idle is ignored
    flush       = 1'b1;
    fetch_start = 1'b1;
    pc          = 8'h33;
    tick();
    flush       = 1'b0;
    fetch_start = 1'b0;
    check_settled("flush_start", 1'b0);
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = 8'hFF;
    tick();
    tick();
    mem_bus.mem_ack   = 1'b0;
    check_settled("idle_ack", 1'b0);

    // asynchronous reset between edges mid-fetch
    fetch_start = 1'b1;
    pc          = 8'h50;
    tick();
    fetch_start       = 1'b0;
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = 8'hAA;
    tick();
    mem_bus.mem_ack   = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    model_instr = '0;
    check_settled("async_reset", 1'b0);
    check("async_reset_addr", {24'd0, mem_bus.mem_addr}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    run_fetch(8'h60, 32'h13579BDF, 0, -1, 1'b0);

`ifdef FETCH_TIMEOUT_EN
    fetch_start = 1'b1;
    pc          = 8'h70;
    tick();
    fetch_start = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i < 16) begin
        check("to_wait_err",  {31'd0, fetch_err}, 32'd0);
        check("to_wait_busy", {31'd0, busy}, 32'd1);
      end
    end
    check("to_err", {31'd0, fetch_err}, 32'd1);
    check_settled("to_idle", 1'b0);
    tick();
    check("to_err_pulse", {31'd0, fetch_err}, 32'd0);
    run_fetch(8'h71, 32'h0BADC0DE, 0, -1, 1'b0);
`else
    fetch_start = 1'b1;
    pc          = 8'h70;
    tick();
    fetch_start = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("nto_busy", {31'd0, busy}, 32'd1);
    check("nto_req",  {31'd0, mem_bus.mem_req}, 32'd1);
    check("nto_err",  {31'd0, fetch_err}, 32'd0);
    check("nto_addr", {24'd0, mem_bus.mem_addr}, 32'h70);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_settled("nto_flush", 1'b0);
`endif

    for (int n = 0; n < 40; n++) begin
      logic [7:0]  ra;
      logic [31:0] rw;
      int          rf;
      ra = 8'($urandom);
      rw = $urandom;
      rf = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_fetch(ra, rw, int'($urandom_range(0, 3)), rf, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 5) == 0) begin
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_settled("rand_flush_idle", 1'b0);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Byte-serial instruction fetch stage sitting directly upstream of the multicycle controller.
- Issues four byte reads over a req/ack memory interface starting at the supplied PC and assembles one 32-bit instruction.
- Presents the instruction, op and funct fields to the controller with a valid flag.
- The instruction is updated atomically, so the controller never sees a partially loaded word.

Parameters:
- ADDR_W, 8, width of pc and mem_addr.
- DATA_W, 8, memory data width; fixed at 8, one byte per beat.
- TIMEOUT_CYCLES, 15, wait-cycle limit per byte; used only with FETCH_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; the block is in reset while reset=0.
- fetch_start  input  1  request a fetch at pc.
- flush  input  1  synchronous cancel of an in-flight fetch.
- pc  input  ADDR_W  byte address of the instruction; sampled when a fetch is accepted.
- mem_req  output  1  memory read request.
- mem_addr  output  ADDR_W  byte address being read.
- mem_ack  input  1  read data valid this cycle.
- mem_rdata  input  8  read byte.
- instr  output  32  last completed instruction.
- op  output  6  instr[31:26].
- funct  output  6  instr[5:0].
- instr_valid  output  1  instr holds a completed fetch that has not been superseded.
- busy  output  1  fetch in progress.
- fetch_err  output  1  one-cycle pulse on timeout; tied 0 without the macro.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; instr=0, op=0, funct=0; instr_valid=0, busy=0, mem_req=0, mem_addr=0, fetch_err=0; byte index=0; shadow=0.
- Reset asserted mid-fetch aborts immediately with the values above.
- States are IDLE, REQ and DONE.
- IDLE/DONE:
  - fetch_start=1 at an edge latches base=pc and sets idx=0.
  - Next state is REQ; instr_valid goes 0 and busy goes 1.
  - instr keeps its old value.
- REQ outputs:
  - mem_req=1.
  - mem_addr=(base+idx) mod 2^ADDR_W; wrap-around is allowed, e.g. base=8'hFE reads FE, FF, 00, 01.
- REQ capture:
  - An edge with mem_ack=1 writes shadow[8*idx+7 : 8*idx]=mem_rdata.
  - Byte 0 is least significant, matching irwrite[0] loading bits 7:0.
  - idx then increments.
- REQ completion:
  - An ack with idx=3 copies the shadow into instr, with byte 3 taken directly from mem_rdata.
  - Next state is DONE; instr_valid=1, busy=0, mem_req=0.
- REQ waiting: mem_ack=0 holds state, idx and mem_addr. mem_req stays high across beats.
- Latency: with mem_ack held at 1, fetch_start is sampled at edge E0, bytes are captured at E1..E4, and instr_valid=1 after E4. Throughput is one instruction per 5 cycles.
- fetch_start while in REQ is ignored; there is no queueing.
- mem_ack while mem_req=0 is ignored.
- flush=1 at an edge in REQ:
  - Next state is IDLE; mem_req=0, busy=0, instr_valid=0.
  - instr is unchanged and the shadow is discarded.
- flush in IDLE/DONE clears instr_valid only.
- flush and fetch_start in the same cycle: flush wins and the fetch is not started.
- op and funct are always combinational slices of the registered instr.

Optional Feature:
- Macro FETCH_TIMEOUT_EN.
- Enabled:
  - A wait counter clears on each ack and on fetch acceptance, and increments each REQ cycle with mem_ack=0.
  - When the counter reaches TIMEOUT_CYCLES, the next edge forces IDLE with mem_req=0, instr_valid=0 and instr unchanged; fetch_err=1 for exactly one cycle.
  - The counter resets to 0.
  - flush takes priority over timeout.
- Disabled: REQ waits indefinitely; fetch_err is constant 0; no counter logic is present.

Decomposition:
- Package mips_pkg contains:
  - fetch_state_t enum (IDLE, REQ, DONE).
  - Field constants OP_MSB=31, OP_LSB=26, FUNCT_MSB=5, FUNCT_LSB=0.
  - BYTES_PER_INSTR=4.
- One sub-module, ir_byte_assembler: the 32-bit shadow register with a byte-indexed write enable and a commit strobe producing instr.
- The FSM, address adder and timeout counter remain in the top module.

Test Plan:
- Reset then fetch at pc=8'h10 with mem_ack held at 1, rdata sequence 20,00,00,8C → mem_addr steps 10,11,12,13; instr=32'h8C000020, op=6'b100011, funct=6'b100000, instr_valid=1 at the 5th edge after fetch_start.
- Wait states: ack only every third cycle → same instr; mem_addr holds during waits; busy=1 throughout; total 12 cycles.
- Wrap: pc=8'hFE → addresses FE, FF, 00, 01; instr assembled correctly.
- fetch_start during REQ is ignored. flush after byte 2 → IDLE, mem_req=0, instr equals the previous instruction, instr_valid=0. flush+fetch_start together → stays IDLE.
- Reset asserted (reset=0) mid-fetch between edges → outputs 0 immediately, without waiting for an edge. Reset released then fetch_start → normal fetch.
- FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=15, mem_ack held at 0 → fetch_err pulses once 16 edges after fetch_start; state IDLE; instr_valid=0.
